core_sequencer: RTL and testbench

Multi-cycle sequencer that drives the single-cycle RV32 core from one shared, variable-latency memory port. It owns the architectural PC and fetches each instruction, then holds instruction and PC stable while the core's combinational datapath settles. For loads and stores it performs the data access. It then issues a one-cycle commit that qualifies the core's register-file write and advances the PC.

---
 rtl/core_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_core_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// ============================================================================
//  Module      : core_sequencer
//  Description : Multi-cycle fetch/execute/memory/commit sequencer driving a
//                single-cycle RV32 core through one shared memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] core_instruction,
  output logic [31:0] core_pc,
  input  logic [31:0] core_memory_address,
  input  logic [31:0] core_data_to_write,
  input  logic [2:0]  core_func3,
  input  logic        core_write_data,
  output logic [31:0] core_read_data,
  input  logic [31:0] core_next_pc,
  output logic        core_step,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [6:0]  c_OP_LOAD   = 7'd3;
  localparam logic [6:0]  c_OP_STORE  = 7'd35;
  localparam logic [6:0]  c_OP_REG    = 7'd51;
  localparam logic [6:0]  c_OP_BRANCH = 7'd99;
  localparam logic [6:0]  c_OP_IMM    = 7'd19;
  localparam logic [6:0]  c_OP_JAL    = 7'd111;
  localparam logic [6:0]  c_OP_LUI    = 7'd55;
  localparam logic [6:0]  c_OP_AUIPC  = 7'd23;
  localparam logic [6:0]  c_OP_JALR   = 7'd103;
  localparam logic [31:0] c_NOP       = 32'h0000_0013;
  localparam logic [2:0]  c_FUNC3_WORD = 3'b010;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_rdata;
  logic [31:0] r_retired;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_mem_func3;
  logic        r_halted;
  logic        r_fault;

  logic        w_legal;
  logic        w_is_mem;
  logic        w_pc_aligned;

  always_comb begin
    w_legal  = 1'b0;
    w_is_mem = 1'b0;
    case (r_instr[6:0])
      c_OP_LOAD, c_OP_STORE: begin
        w_legal  = 1'b1;
        w_is_mem = 1'b1;
      end
      c_OP_REG, c_OP_BRANCH, c_OP_IMM, c_OP_JAL,
      c_OP_LUI, c_OP_AUIPC, c_OP_JALR: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_pc_aligned = (core_next_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= c_NOP;
      r_rdata     <= 32'h0;
      r_retired   <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_func3 <= 3'b000;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (halt_req) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state     <= S_FETCH;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_pc;
            r_mem_func3 <= c_FUNC3_WORD;
          end
        end

        S_FETCH: begin
          if (mem_ready) begin
            r_instr   <= mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (!w_legal) begin
            r_state  <= S_FAULT;
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
          end else if (w_is_mem) begin
            // The core's address/data have settled during this cycle, so
            // they are captured here and held for the whole access.
            r_state     <= S_MEM;
            r_mem_req   <= 1'b1;
            r_mem_we    <= core_write_data;
            r_mem_addr  <= core_memory_address;
            r_mem_wdata <= core_data_to_write;
            r_mem_func3 <= core_func3;
          end else begin
            r_state <= S_COMMIT;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          if (!w_pc_aligned) begin
            r_state  <= S_FAULT;
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
          end else begin
            r_pc      <= core_next_pc;
            r_retired <= r_retired + 32'd1;
            if (halt_req) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= core_next_pc;
              r_mem_func3 <= c_FUNC3_WORD;
            end
          end
        end

        S_HALT: begin
          if (!halt_req) begin
            r_state     <= S_FETCH;
            r_halted    <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_pc;
            r_mem_func3 <= c_FUNC3_WORD;
          end
        end

        S_FAULT: begin
          r_state <= S_FAULT;
        end

        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Commit strobe depends on the core's next PC in the same cycle, so it is
  // decoded from state rather than registered.
  assign core_step        = (r_state == S_COMMIT) && w_pc_aligned;

  assign mem_req          = r_mem_req;
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign mem_func3        = r_mem_func3;
  assign core_instruction = r_instr;
  assign core_pc          = r_pc;
  assign core_read_data   = r_rdata;
  assign halted           = r_halted;
  assign fault            = r_fault;
  assign retired_count    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ============================================================================
//  Module      : tb_core_sequencer
//  Description : Directed self-checking bench for core_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_sequencer;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] core_instruction;
  logic [31:0] core_pc;
  logic [31:0] core_memory_address;
  logic [31:0] core_data_to_write;
  logic [2:0]  core_func3;
  logic        core_write_data;
  logic [31:0] core_read_data;
  logic [31:0] core_next_pc;
  logic        core_step;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] c_ADDI = 32'h0050_0093;
  localparam logic [31:0] c_LW   = 32'h0002_A183;
  localparam logic [31:0] c_SW   = 32'h0020_A023;
  localparam logic [31:0] c_ILL  = 32'h0000_007F;

  core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_func3           (mem_func3),
    .mem_ready           (mem_ready),
    .mem_rdata           (mem_rdata),
    .core_instruction    (core_instruction),
    .core_pc             (core_pc),
    .core_memory_address (core_memory_address),
    .core_data_to_write  (core_data_to_write),
    .core_func3          (core_func3),
    .core_write_data     (core_write_data),
    .core_read_data      (core_read_data),
    .core_next_pc        (core_next_pc),
    .core_step           (core_step),
    .halt_req            (halt_req),
    .halted              (halted),
    .fault               (fault),
    .retired_count       (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expects the DUT in FETCH at pc; answers with zero wait and returns in EXEC.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    check_value("fetch_req", {31'd0, mem_req}, 32'd1);
    check_value("fetch_addr", mem_addr, pc);
    check_value("fetch_we", {31'd0, mem_we}, 32'd0);
    check_value("fetch_func3", {29'd0, mem_func3}, 32'd2);
    mem_ready = 1'b1;
    mem_rdata = instr;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    core_memory_address = 32'h0; core_data_to_write = 32'h0;
    core_func3 = 3'b000; core_write_data = 1'b0; core_next_pc = 32'h0;
    halt_req = 1'b0;
    repeat (2) @(negedge clk);

    check_value("rst_req", {31'd0, mem_req}, 32'd0);
    check_value("rst_we", {31'd0, mem_we}, 32'd0);
    check_value("rst_step", {31'd0, core_step}, 32'd0);
    check_value("rst_halted", {31'd0, halted}, 32'd0);
    check_value("rst_fault", {31'd0, fault}, 32'd0);
    check_value("rst_pc", core_pc, 32'h0);
    check_value("rst_instr", core_instruction, 32'h0000_0013);
    check_value("rst_rdata", core_read_data, 32'h0);
    check_value("rst_retired", retired_count, 32'h0);
    rst_n = 1'b1;

    // addi, zero wait: FETCH, EXEC, COMMIT
    @(negedge clk);
    fetch(32'h0, c_ADDI);
    check_value("addi_exec_req", {31'd0, mem_req}, 32'd0);
    check_value("addi_instr", core_instruction, c_ADDI);
    check_value("addi_exec_step", {31'd0, core_step}, 32'd0);
    core_next_pc = 32'h4;
    @(negedge clk);
    check_value("addi_step", {31'd0, core_step}, 32'd1);
    check_value("addi_commit_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check_value("addi_pc", core_pc, 32'h4);
    check_value("addi_retired", retired_count, 32'd1);
    check_value("addi_step_one", {31'd0, core_step}, 32'd0);

    // lw with two read wait states
    fetch(32'h4, c_LW);
    core_memory_address = 32'h100; core_func3 = 3'b010;
    core_write_data = 1'b0; core_next_pc = 32'h8;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check_value("lw_req", {31'd0, mem_req}, 32'd1);
      check_value("lw_addr", mem_addr, 32'h100);
      check_value("lw_we", {31'd0, mem_we}, 32'd0);
      check_value("lw_wait_step", {31'd0, core_step}, 32'd0);
      if (w == 2) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check_value("lw_step", {31'd0, core_step}, 32'd1);
    check_value("lw_rdata", core_read_data, 32'hDEAD_BEEF);
    check_value("lw_commit_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check_value("lw_pc", core_pc, 32'h8);
    check_value("lw_retired", retired_count, 32'd2);

    // sw, zero wait
    fetch(32'h8, c_SW);
    core_write_data = 1'b1; core_data_to_write = 32'h1234_5678;
    core_func3 = 3'b010; core_memory_address = 32'h200; core_next_pc = 32'hC;
    @(negedge clk);
    check_value("sw_req", {31'd0, mem_req}, 32'd1);
    check_value("sw_we", {31'd0, mem_we}, 32'd1);
    check_value("sw_wdata", mem_wdata, 32'h1234_5678);
    check_value("sw_func3", {29'd0, mem_func3}, 32'd2);
    check_value("sw_addr", mem_addr, 32'h200);
    mem_ready = 1'b1;
    mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    mem_ready = 1'b0;
    core_write_data = 1'b0;
    check_value("sw_step", {31'd0, core_step}, 32'd1);
    check_value("sw_rdata_kept", core_read_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check_value("sw_retired", retired_count, 32'd3);

    // halt raised during MEM
    fetch(32'hC, c_LW);
    core_memory_address = 32'h104; core_next_pc = 32'h10;
    @(negedge clk);
    halt_req = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0055;
    @(negedge clk);
    mem_ready = 1'b0;
    check_value("halt_commit_step", {31'd0, core_step}, 32'd1);
    check_value("halt_commit_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    check_value("halt_halted", {31'd0, halted}, 32'd1);
    check_value("halt_req_out", {31'd0, mem_req}, 32'd0);
    check_value("halt_pc", core_pc, 32'h10);
    check_value("halt_retired", retired_count, 32'd4);
    check_value("halt_rdata", core_read_data, 32'h55);
    @(negedge clk);
    check_value("halt_hold", {31'd0, halted}, 32'd1);
    check_value("halt_hold_req", {31'd0, mem_req}, 32'd0);
    halt_req = 1'b0;
    @(negedge clk);
    check_value("resume_halted", {31'd0, halted}, 32'd0);

    // illegal opcode
    fetch(32'h10, c_ILL);
    check_value("ill_exec_step", {31'd0, core_step}, 32'd0);
    @(negedge clk);
    check_value("ill_fault", {31'd0, fault}, 32'd1);
    check_value("ill_halted", {31'd0, halted}, 32'd1);
    check_value("ill_req", {31'd0, mem_req}, 32'd0);
    check_value("ill_step", {31'd0, core_step}, 32'd0);
    check_value("ill_retired", retired_count, 32'd4);
    check_value("ill_pc", core_pc, 32'h10);
    repeat (3) @(negedge clk);
    check_value("ill_sticky", {31'd0, fault}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_value("ill_rst_fault", {31'd0, fault}, 32'd0);
    check_value("ill_rst_pc", core_pc, 32'h0);
    rst_n = 1'b1;

    // misaligned next PC
    @(negedge clk);
    fetch(32'h0, c_ADDI);
    core_next_pc = 32'h102;
    @(negedge clk);
    check_value("mis_step", {31'd0, core_step}, 32'd0);
    @(negedge clk);
    check_value("mis_fault", {31'd0, fault}, 32'd1);
    check_value("mis_pc", core_pc, 32'h0);
    check_value("mis_retired", retired_count, 32'd0);
    repeat (3) @(negedge clk);
    check_value("mis_sticky", {31'd0, fault}, 32'd1);
    check_value("mis_sticky_req", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // reset pulsed during a MEM wait
    @(negedge clk);
    fetch(32'h0, c_ADDI);
    core_next_pc = 32'h4;
    @(negedge clk);
    @(negedge clk);
    check_value("pre_rst_retired", retired_count, 32'd1);
    fetch(32'h4, c_LW);
    core_memory_address = 32'h100; core_next_pc = 32'h8;
    @(negedge clk);
    check_value("mid_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_value("async_req", {31'd0, mem_req}, 32'd0);
    check_value("async_pc", core_pc, 32'h0);
    check_value("async_retired", retired_count, 32'd0);
    check_value("async_step", {31'd0, core_step}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("refetch_req", {31'd0, mem_req}, 32'd1);
    check_value("refetch_addr", mem_addr, 32'h0);
    check_value("refetch_retired", retired_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
